// File: rtl/rgb2udp_pkt_if.sv
// rtl/rgb2udp_pkt_if.sv - video input and UDP TX handshake bundle for rgb2udp_pkt
// Purpose: groups the synchronised video stream and the TX arbiter handshake.
// Signals:
//   vid_de, vid_hsync, vid_vsync, vid_rgb[23:0]  video stream into the packetiser ({R,B,G})
//   w_req, w_ack                                  TX slot request / one-cycle grant
//   w_enable, w_data[31:0]                        payload word stream out of the packetiser
// Modports: master = packetiser side, slave = video source / TX arbiter side.
interface rgb2udp_pkt_if;
  logic        vid_de;
  logic        vid_hsync;
  logic        vid_vsync;
  logic [23:0] vid_rgb;
  logic        w_req;
  logic        w_ack;
  logic        w_enable;
  logic [31:0] w_data;

  modport master (
    input  vid_de, vid_hsync, vid_vsync, vid_rgb, w_ack,
    output w_req, w_enable, w_data
  );

  modport slave (
    output vid_de, vid_hsync, vid_vsync, vid_rgb, w_ack,
    input  w_req, w_enable, w_data
  );
endinterface

// File: rtl/rgb2udp_pkt.sv
// rtl/rgb2udp_pkt.sv - decimating RGB video to fixed-size UDP payload packetiser
// Purpose: decimates the pixel stream in H/V/frame, buffers {v,h,RGB} samples in a
//   first-word-fall-through FIFO and emits header + PIX_PER_PKT pixel words per
//   packet once the TX arbiter grants a slot.
// Ports:
//   clk        system clock (video already synchronous to it)
//   rst        synchronous reset, active high
//   bus        rgb2udp_pkt_if.master: vid_* in, w_ack in, w_req/w_enable/w_data out
//   ovf        sticky flag, a pixel was dropped on a full FIFO
//   drop_cnt   dropped-pixel count, saturating
// Optional feature macro: RGB2UDP_SEQ_EN adds header word 5 {frame_cnt, pkt_in_frame}.
module rgb2udp_pkt #(
  parameter int          PIX_PER_PKT = 200,
  parameter int          FIFO_AW     = 11,
  parameter int          H_DEC_LOG2  = 2,
  parameter int          V_DEC_LOG2  = 2,
  parameter int          F_DEC_LOG2  = 4,
  parameter logic [31:0] DST_IP      = 32'h0a000003,
  parameter logic [31:0] SRC_IP      = 32'h0a000001,
  parameter logic [31:0] PORTS       = 32'h40004000
) (
  input  logic               clk,
  input  logic               rst,
  rgb2udp_pkt_if.master      bus,
  output logic               ovf,
  output logic [15:0]        drop_cnt
);

`ifdef RGB2UDP_SEQ_EN
  localparam int NH = 6;
`else
  localparam int NH = 5;
`endif
  localparam int          DEPTH  = 1 << FIFO_AW;
  localparam logic [31:0] LEN    = 32'(4 * (PIX_PER_PKT + NH - 4));
  localparam logic [11:0] H_MASK = 12'((1 << H_DEC_LOG2) - 1);
  localparam logic [11:0] V_MASK = 12'((1 << V_DEC_LOG2) - 1);
  localparam logic [15:0] F_MASK = 16'((1 << F_DEC_LOG2) - 1);

  typedef enum logic [1:0] {IDLE, WAIT, HDR, DATA} state_t;

  state_t       state, state_nxt;
  logic [9:0]   idx, idx_nxt;
  logic         pop, en_nxt;
  logic [31:0]  data_nxt;

  logic [11:0]  h_cnt, v_cnt;
  logic [15:0]  frame_cnt;
  logic         de_d, vsync_d, flush_pend;
  logic         vsync_rise, keep, push, push_ok, drop, full, flush;

  logic [47:0]        mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count;
  logic [47:0]        head;

`ifdef RGB2UDP_SEQ_EN
  logic [15:0]  pkt_in_frame;
`endif

  assign vsync_rise = bus.vid_vsync & ~vsync_d;
  assign keep       = ((h_cnt & H_MASK) == 12'd0) && ((v_cnt & V_MASK) == 12'd0) &&
                      ((frame_cnt & F_MASK) == 16'd0);
  assign push       = bus.vid_de & keep & ~flush_pend;
  assign full       = (count == (FIFO_AW+1)'(DEPTH));
  // A pop in the same cycle frees the slot, so a push on full is still accepted.
  assign push_ok    = push & (~full | pop);
  assign drop       = push & full & ~pop;
  assign flush      = (state == IDLE) & flush_pend;
  assign head       = mem[rd_ptr];
  assign bus.w_req  = (state == WAIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt     <= '0;
      v_cnt     <= '0;
      frame_cnt <= '0;
      de_d      <= 1'b0;
      vsync_d   <= 1'b0;
    end else begin
      de_d    <= bus.vid_de;
      vsync_d <= bus.vid_vsync;
      if (bus.vid_hsync)             h_cnt <= '0;
      else if (bus.vid_de)           h_cnt <= h_cnt + 12'd1;
      if (bus.vid_vsync)             v_cnt <= '0;
      else if (de_d && !bus.vid_de)  v_cnt <= v_cnt + 12'd1;
      if (vsync_rise)                frame_cnt <= frame_cnt + 16'd1;
    end
  end

  // Sample storage is not reset; pointers and count define its validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= {v_cnt, h_cnt, bus.vid_rgb[23:16], bus.vid_rgb[7:0], bus.vid_rgb[15:8]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      flush_pend <= 1'b0;
      ovf        <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + FIFO_AW'(1);
        if (pop)     rd_ptr <= rd_ptr + FIFO_AW'(1);
        case ({push_ok, pop})
          2'b10:   count <= count + (FIFO_AW+1)'(1);
          2'b01:   count <= count - (FIFO_AW+1)'(1);
          default: count <= count;
        endcase
      end
      if (vsync_rise) flush_pend <= 1'b1;
      else if (flush) flush_pend <= 1'b0;
      if (drop) begin
        ovf <= 1'b1;
        if (drop_cnt != 16'hffff) drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= '0;
      bus.w_enable <= 1'b0;
      bus.w_data   <= '0;
    end else begin
      state        <= state_nxt;
      idx          <= idx_nxt;
      bus.w_enable <= en_nxt;
      bus.w_data   <= data_nxt;
    end
  end

`ifdef RGB2UDP_SEQ_EN
  always_ff @(posedge clk) begin
    if (rst || flush)                                pkt_in_frame <= '0;
    else if (state == HDR && idx == 10'(NH - 1))     pkt_in_frame <= pkt_in_frame + 16'd1;
  end
`endif

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    pop       = 1'b0;
    en_nxt    = 1'b0;
    data_nxt  = '0;
    case (state)
      IDLE: begin
        if (!flush_pend && 32'(count) >= 32'(PIX_PER_PKT)) state_nxt = WAIT;
      end
      WAIT: begin
        if (bus.w_ack) begin
          state_nxt = HDR;
          idx_nxt   = '0;
        end
      end
      HDR: begin
        en_nxt = 1'b1;
        case (idx)
          10'd0:   data_nxt = DST_IP;
          10'd1:   data_nxt = SRC_IP;
          10'd2:   data_nxt = PORTS;
          10'd3:   data_nxt = LEN;
          10'd4:   data_nxt = {4'h0, head[47:36], 4'h0, head[35:24]};
`ifdef RGB2UDP_SEQ_EN
          default: data_nxt = {frame_cnt, pkt_in_frame};
`else
          default: data_nxt = '0;
`endif
        endcase
        if (idx == 10'(NH - 1)) begin
          state_nxt = DATA;
          idx_nxt   = '0;
        end else begin
          idx_nxt = idx + 10'd1;
        end
      end
      DATA: begin
        en_nxt   = 1'b1;
        pop      = 1'b1;
        data_nxt = {head[23:0], 8'hff};
        if (idx == 10'(PIX_PER_PKT - 1)) begin
          state_nxt = IDLE;
          idx_nxt   = '0;
        end else begin
          idx_nxt = idx + 10'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
